// File: rtl/wg_warp_sequencer_pkg.sv
// Shared sizing for the workgroup-to-warp sequencer: slot table geometry,
// default warp/tag widths and the FSM state type.
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef WTAG_WIDTH
`define WTAG_WIDTH (WG_SLOT_W + DEPTH_WARP)
`endif

package wg_warp_sequencer_pkg;
  localparam int unsigned NUM_WG_SLOT = 4;
  localparam int unsigned WG_SLOT_W   = 2;

  typedef enum logic {
    IDLE,
    ISSUE
  } seq_state_e;
endpackage

// File: rtl/fixed_pri_arb.sv
// Fixed-priority arbiter: one-hot grant to the lowest set request bit.
module fixed_pri_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam logic [N-1:0] ONE = 1;

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & ((~req) + ONE);
endmodule

// File: rtl/one2bin.sv
// One-hot to binary encoder; all-zero input encodes to zero.
module one2bin #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] oh,
  output logic [W-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (oh[i]) bin = bin | W'(i);
    end
  end
endmodule

// File: rtl/wg_warp_sequencer.sv
// Expands workgroup requests into per-warp requests, tracks outstanding warps
// per workgroup slot and reports workgroup completion back to the CTA scheduler.
module wg_warp_sequencer
  import wg_warp_sequencer_pkg::*;
#(
  parameter int unsigned NUM_WARP   = `NUM_WARP,
  parameter int unsigned DEPTH_WARP = `DEPTH_WARP,
  parameter int unsigned TAG_WIDTH  = `TAG_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wg_req_valid_i,
  output logic                              wg_req_ready_o,
  input  logic [TAG_WIDTH-1:0]              wg_req_tag_i,
  input  logic [DEPTH_WARP:0]               wg_req_nwarp_i,
  output logic                              warp_req_valid_o,
  input  logic                              warp_req_ready_i,
  output logic [WG_SLOT_W+DEPTH_WARP-1:0]   warp_req_tag_o,
  input  logic                              warp_done_valid_i,
  output logic                              warp_done_ready_o,
  input  logic [WG_SLOT_W+DEPTH_WARP-1:0]   warp_done_tag_i,
  output logic                              wg_done_valid_o,
  input  logic                              wg_done_ready_i,
  output logic [TAG_WIDTH-1:0]              wg_done_tag_o,
  output logic                              err_o
);
  localparam int unsigned WTAG_W = `WTAG_WIDTH;
  localparam logic [DEPTH_WARP:0] ONE_W     = 1;
  localparam logic [DEPTH_WARP:0] NWARP_MAX = (DEPTH_WARP+1)'(NUM_WARP);

  seq_state_e state, state_nxt;

  logic [NUM_WG_SLOT-1:0] slot_vld;
  logic [NUM_WG_SLOT-1:0] slot_done_pend;
  logic [TAG_WIDTH-1:0]   slot_tag [NUM_WG_SLOT];
  logic [DEPTH_WARP:0]    slot_rem [NUM_WG_SLOT];

  logic [WG_SLOT_W-1:0]   cur_slot;
  logic [DEPTH_WARP:0]    cur_n;
  logic [DEPTH_WARP:0]    cnt;
  logic                   err_q;

  logic [NUM_WG_SLOT-1:0] free_gnt, done_gnt;
  logic [WG_SLOT_W-1:0]   free_slot, done_slot;

  logic                   wg_accept, warp_fire, done_fire;
  logic                   nwarp_over;
  logic [DEPTH_WARP:0]    nwarp_eff;
  logic [WG_SLOT_W-1:0]   dn_slot;
  logic                   dn_ok;
  logic                   unused_warp_idx;

  fixed_pri_arb #(.N(NUM_WG_SLOT)) u_free_arb (
    .req (~slot_vld),
    .gnt (free_gnt)
  );
  one2bin #(.N(NUM_WG_SLOT), .W(WG_SLOT_W)) u_free_enc (
    .oh  (free_gnt),
    .bin (free_slot)
  );
  fixed_pri_arb #(.N(NUM_WG_SLOT)) u_done_arb (
    .req (slot_done_pend),
    .gnt (done_gnt)
  );
  one2bin #(.N(NUM_WG_SLOT), .W(WG_SLOT_W)) u_done_enc (
    .oh  (done_gnt),
    .bin (done_slot)
  );

  // Free vector comes straight from registered vld, so a slot released by a
  // wg_done fire is only allocatable from the following cycle.
  assign wg_req_ready_o    = (state == IDLE) && (|(~slot_vld));
  assign warp_req_valid_o  = (state == ISSUE);
  assign warp_req_tag_o    = {cur_slot, cnt[DEPTH_WARP-1:0]};
  assign warp_done_ready_o = 1'b1;
  assign wg_done_valid_o   = |slot_done_pend;
  assign wg_done_tag_o     = slot_tag[done_slot];
  assign err_o             = err_q;

  assign wg_accept  = wg_req_valid_i && wg_req_ready_o;
  assign warp_fire  = warp_req_valid_o && warp_req_ready_i;
  assign done_fire  = wg_done_valid_o && wg_done_ready_i;
  assign nwarp_over = wg_req_nwarp_i > NWARP_MAX;
  assign nwarp_eff  = nwarp_over ? NWARP_MAX : wg_req_nwarp_i;

  assign dn_slot         = warp_done_tag_i[WTAG_W-1 -: WG_SLOT_W];
  assign dn_ok           = slot_vld[dn_slot] && (slot_rem[dn_slot] != '0);
  assign unused_warp_idx = ^warp_done_tag_i[DEPTH_WARP-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wg_accept && nwarp_eff != '0) state_nxt = ISSUE;
      ISSUE:   if (warp_fire && cnt == cur_n - ONE_W) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld       <= '0;
      slot_done_pend <= '0;
      for (int unsigned i = 0; i < NUM_WG_SLOT; i++) begin
        slot_tag[i] <= '0;
        slot_rem[i] <= '0;
      end
      cur_slot <= '0;
      cur_n    <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      if (warp_done_valid_i) begin
        if (dn_ok) begin
          slot_rem[dn_slot] <= slot_rem[dn_slot] - ONE_W;
          if (slot_rem[dn_slot] == ONE_W) slot_done_pend[dn_slot] <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end

      // Accept targets a free slot, so it never collides with the vld-gated
      // retire above or the done-fire clear below.
      if (wg_accept) begin
        slot_vld[free_slot]       <= 1'b1;
        slot_tag[free_slot]       <= wg_req_tag_i;
        slot_rem[free_slot]       <= nwarp_eff;
        slot_done_pend[free_slot] <= (nwarp_eff == '0);
        cur_slot                  <= free_slot;
        cur_n                     <= nwarp_eff;
        cnt                       <= '0;
        if (nwarp_over) err_q <= 1'b1;
      end else if (warp_fire) begin
        cnt <= cnt + ONE_W;
      end

      if (done_fire) begin
        slot_vld[done_slot]       <= 1'b0;
        slot_done_pend[done_slot] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wg_warp_sequencer.sv
// Directed bench for wg_warp_sequencer with NUM_WARP=8, 8-bit workgroup tags.
module tb_wg_warp_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wg_req_valid_i, wg_req_ready_o;
  logic [7:0] wg_req_tag_i;
  logic [3:0] wg_req_nwarp_i;
  logic       warp_req_valid_o, warp_req_ready_i;
  logic [4:0] warp_req_tag_o;
  logic       warp_done_valid_i, warp_done_ready_o;
  logic [4:0] warp_done_tag_i;
  logic       wg_done_valid_o, wg_done_ready_i;
  logic [7:0] wg_done_tag_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wg_warp_sequencer #(.NUM_WARP(8), .DEPTH_WARP(3), .TAG_WIDTH(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wg_req_valid_i    (wg_req_valid_i),
    .wg_req_ready_o    (wg_req_ready_o),
    .wg_req_tag_i      (wg_req_tag_i),
    .wg_req_nwarp_i    (wg_req_nwarp_i),
    .warp_req_valid_o  (warp_req_valid_o),
    .warp_req_ready_i  (warp_req_ready_i),
    .warp_req_tag_o    (warp_req_tag_o),
    .warp_done_valid_i (warp_done_valid_i),
    .warp_done_ready_o (warp_done_ready_o),
    .warp_done_tag_i   (warp_done_tag_i),
    .wg_done_valid_o   (wg_done_valid_o),
    .wg_done_ready_i   (wg_done_ready_i),
    .wg_done_tag_o     (wg_done_tag_o),
    .err_o             (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wg_req_valid_i    = 1'b0;
    wg_req_tag_i      = '0;
    wg_req_nwarp_i    = '0;
    warp_req_ready_i  = 1'b0;
    warp_done_valid_i = 1'b0;
    warp_done_tag_i   = '0;
    wg_done_ready_i   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_warp_valid got %0b exp 0", warp_req_valid_o); end
    checks++; if (warp_req_tag_o !== 5'd0) begin errors++; $display("FAIL reset_warp_tag got %0h exp 0", warp_req_tag_o); end
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %0b exp 0", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'd0) begin errors++; $display("FAIL reset_done_tag got %0h exp 0", wg_done_tag_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_o); end
    checks++; if (warp_done_ready_o !== 1'b1) begin errors++; $display("FAIL reset_done_ready got %0b exp 1", warp_done_ready_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", wg_req_ready_o); end
  endtask

  task automatic test_basic();
    do_reset();
    warp_req_ready_i = 1'b1;
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h15; wg_req_nwarp_i = 4'd3;
    tick();
    wg_req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (warp_req_valid_o !== 1'b1) begin errors++; $display("FAIL basic_warp_valid[%0d] got %0b exp 1", i, warp_req_valid_o); end
      checks++; if (warp_req_tag_o !== 5'(i)) begin errors++; $display("FAIL basic_warp_tag[%0d] got %0h exp %0h", i, warp_req_tag_o, 5'(i)); end
      checks++; if (wg_req_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_in_issue[%0d] got %0b exp 0", i, wg_req_ready_o); end
      tick();
    end
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL basic_warp_idle got %0b exp 0", warp_req_valid_o); end
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_idle got %0b exp 1", wg_req_ready_o); end
    warp_done_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      warp_done_tag_i = 5'(i);
      checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d] got %0b exp 0", i, wg_done_valid_o); end
      tick();
    end
    warp_done_valid_i = 1'b0;
    checks++; if (wg_done_valid_o !== 1'b1) begin errors++; $display("FAIL basic_done_valid got %0b exp 1", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'h15) begin errors++; $display("FAIL basic_done_tag got %0h exp 15", wg_done_tag_o); end
    wg_done_ready_i = 1'b1;
    tick();
    wg_done_ready_i = 1'b0;
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL basic_done_clear got %0b exp 0", wg_done_valid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err got %0b exp 0", err_o); end
  endtask

  task automatic test_stall();
    logic [4:0] pat;
    int exp_cnt;
    int fires;
    pat = 5'b11001;
    exp_cnt = 0;
    fires = 0;
    do_reset();
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h15; wg_req_nwarp_i = 4'd3;
    tick();
    wg_req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      warp_req_ready_i = pat[i];
      checks++; if (warp_req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 1", i, warp_req_valid_o); end
      checks++; if (warp_req_tag_o !== 5'(exp_cnt)) begin errors++; $display("FAIL stall_tag[%0d] got %0h exp %0h", i, warp_req_tag_o, 5'(exp_cnt)); end
      if (warp_req_valid_o && warp_req_ready_i) fires++;
      tick();
      if (pat[i]) exp_cnt++;
    end
    warp_req_ready_i = 1'b0;
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %0b exp 0", warp_req_valid_o); end
    checks++; if (fires !== 3) begin errors++; $display("FAIL stall_fires got %0d exp 3", fires); end
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_idle_ready got %0b exp 1", wg_req_ready_o); end
  endtask

  task automatic test_full();
    do_reset();
    warp_req_ready_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h20 + 8'(s); wg_req_nwarp_i = 4'd1;
      tick();
      wg_req_valid_i = 1'b0;
      checks++; if (warp_req_tag_o !== 5'(s * 8)) begin errors++; $display("FAIL full_slot_tag[%0d] got %0h exp %0h", s, warp_req_tag_o, 5'(s * 8)); end
      tick();
    end
    checks++; if (wg_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", wg_req_ready_o); end
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h30; wg_req_nwarp_i = 4'd2;
    warp_done_valid_i = 1'b1; warp_done_tag_i = 5'd16;
    tick();
    warp_done_tag_i = 5'd0;
    tick();
    warp_done_valid_i = 1'b0;
    checks++; if (wg_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_pend got %0b exp 0", wg_req_ready_o); end
    checks++; if (wg_done_valid_o !== 1'b1) begin errors++; $display("FAIL full_done_valid got %0b exp 1", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'h20) begin errors++; $display("FAIL full_done_first got %0h exp 20", wg_done_tag_o); end
    wg_done_ready_i = 1'b1;
    tick();
    checks++; if (wg_done_tag_o !== 8'h22) begin errors++; $display("FAIL full_done_second got %0h exp 22", wg_done_tag_o); end
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL full_no_early_accept got %0b exp 0", warp_req_valid_o); end
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_free got %0b exp 1", wg_req_ready_o); end
    tick();
    wg_req_valid_i = 1'b0;
    wg_done_ready_i = 1'b0;
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL full_done_drained got %0b exp 0", wg_done_valid_o); end
    checks++; if (warp_req_valid_o !== 1'b1) begin errors++; $display("FAIL full_fifth_valid got %0b exp 1", warp_req_valid_o); end
    checks++; if (warp_req_tag_o !== 5'd0) begin errors++; $display("FAIL full_fifth_tag0 got %0h exp 0", warp_req_tag_o); end
    tick();
    checks++; if (warp_req_tag_o !== 5'd1) begin errors++; $display("FAIL full_fifth_tag1 got %0h exp 1", warp_req_tag_o); end
    tick();
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL full_fifth_end got %0b exp 0", warp_req_valid_o); end
  endtask

  task automatic test_zero_and_clamp();
    int n;
    do_reset();
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h07; wg_req_nwarp_i = 4'd0;
    tick();
    wg_req_valid_i = 1'b0;
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL zero_no_warp got %0b exp 0", warp_req_valid_o); end
    checks++; if (wg_done_valid_o !== 1'b1) begin errors++; $display("FAIL zero_done_valid got %0b exp 1", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'h07) begin errors++; $display("FAIL zero_done_tag got %0h exp 07", wg_done_tag_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL zero_err got %0b exp 0", err_o); end
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL zero_idle got %0b exp 1", wg_req_ready_o); end
    wg_done_ready_i = 1'b1;
    tick();
    wg_done_ready_i = 1'b0;
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL zero_done_clear got %0b exp 0", wg_done_valid_o); end

    do_reset();
    warp_req_ready_i = 1'b1;
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h09; wg_req_nwarp_i = 4'd11;
    tick();
    wg_req_valid_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && warp_req_valid_o; k++) begin
      checks++; if (warp_req_tag_o !== 5'(n)) begin errors++; $display("FAIL clamp_tag[%0d] got %0h exp %0h", n, warp_req_tag_o, 5'(n)); end
      n++;
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL clamp_count got %0d exp 8", n); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clamp_err got %0b exp 1", err_o); end
  endtask

  task automatic test_bad_done();
    do_reset();
    warp_done_valid_i = 1'b1; warp_done_tag_i = 5'd8;
    tick();
    warp_done_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bad_err got %0b exp 1", err_o); end
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL bad_no_done got %0b exp 0", wg_done_valid_o); end
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL bad_ready got %0b exp 1", wg_req_ready_o); end
    warp_req_ready_i = 1'b1;
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h44; wg_req_nwarp_i = 4'd1;
    tick();
    wg_req_valid_i = 1'b0;
    checks++; if (warp_req_tag_o !== 5'd0) begin errors++; $display("FAIL bad_slot0 got %0h exp 0", warp_req_tag_o); end
    tick();
    warp_done_valid_i = 1'b1; warp_done_tag_i = 5'd0;
    tick();
    warp_done_valid_i = 1'b0;
    checks++; if (wg_done_valid_o !== 1'b1) begin errors++; $display("FAIL bad_done_valid got %0b exp 1", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'h44) begin errors++; $display("FAIL bad_done_tag got %0h exp 44", wg_done_tag_o); end
    repeat (3) tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bad_err_sticky got %0b exp 1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bad_err_cleared got %0b exp 0", err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    warp_req_ready_i = 1'b1;
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h5a; wg_req_nwarp_i = 4'd5;
    tick();
    wg_req_valid_i = 1'b0;
    tick();
    tick();
    checks++; if (warp_req_tag_o !== 5'd2) begin errors++; $display("FAIL mid_progress got %0h exp 2", warp_req_tag_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL mid_warp_valid got %0b exp 0", warp_req_valid_o); end
    checks++; if (warp_req_tag_o !== 5'd0) begin errors++; $display("FAIL mid_warp_tag got %0h exp 0", warp_req_tag_o); end
    checks++; if (wg_done_valid_o !== 1'b0) begin errors++; $display("FAIL mid_done_valid got %0b exp 0", wg_done_valid_o); end
    checks++; if (wg_done_tag_o !== 8'd0) begin errors++; $display("FAIL mid_done_tag got %0h exp 0", wg_done_tag_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err got %0b exp 0", err_o); end
    warp_req_ready_i = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++; if (wg_req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b exp 1", wg_req_ready_o); end
    checks++; if (warp_req_valid_o !== 1'b0) begin errors++; $display("FAIL mid_idle got %0b exp 0", warp_req_valid_o); end
    wg_req_valid_i = 1'b1; wg_req_tag_i = 8'h01; wg_req_nwarp_i = 4'd1;
    tick();
    wg_req_valid_i = 1'b0;
    checks++; if (warp_req_tag_o !== 5'd0) begin errors++; $display("FAIL mid_empty_slot0 got %0h exp 0", warp_req_tag_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_zero_and_clamp();
    test_bad_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
